loopback_pipe: RTL and testbench
================================

LOOPBACK_PIPE -- requirements
Module: loopback_pipe

Interface
REQ-001 Parameter STF_WIDTH, default 24: stimulus FIFO data width.
REQ-002 Parameter RTF_WIDTH, default 24: result FIFO data width.
REQ-003 Parameter LATENCY, default 2, legal 1..8: extra register stages between capture and output buffer.
REQ-004 Parameter BUF_DEPTH, default 8, power of 2, >= LATENCY+2: output buffer depth in words.
REQ-005 clock  input  1  rising-edge clock.
REQ-006 reset_n  input  1  reset, asynchronous, active-low.
REQ-007 enable  input  1  high permits new stimulus reads.
REQ-008 mode  input  2  transform: 0 pass, 1 invert, 2 add sequence number, 3 discard.
REQ-009 sfifo_data  input  STF_WIDTH  stimulus word, valid the cycle after sfifo_rdreq.
REQ-010 sfifo_rdreq  output  1  stimulus read strobe.
REQ-011 sfifo_rdempty  input  1  stimulus FIFO empty.
REQ-012 rfifo_data  output  RTF_WIDTH  result word.
REQ-013 rfifo_wrreq  output  1  result write strobe.
REQ-014 rfifo_wrfull  input  1  result FIFO full.
REQ-015 xfer_count  output  32  results written since reset.
REQ-016 idle  output  1  no word in flight or buffered.

Function
REQ-017 sfifo_rdreq SHALL be high iff enable & ~sfifo_rdempty & (inflight + buf_count < BUF_DEPTH); inflight counts reads not yet entered into the buffer (including discards until their retire cycle).
REQ-018 A read at cycle N SHALL capture sfifo_data at edge N+1, together with the mode sampled at cycle N.
REQ-019 The captured word SHALL be resized to RTF_WIDTH: zero-extended if STF_WIDTH < RTF_WIDTH, low bits kept if larger.
REQ-020 Transform: mode 0 unchanged; mode 1 bitwise inverted; mode 2 word + seq mod 2^RTF_WIDTH, seq = 0 after reset, +1 per mode-2 word; mode 3 word marked discard.
REQ-021 Transformed word SHALL traverse LATENCY register stages, then be written into the buffer; discard-marked words SHALL retire from inflight there, not enter the buffer.
REQ-022 Total latency, read strobe to earliest rfifo_wrreq, SHALL be LATENCY+2 cycles with an empty buffer and rfifo_wrfull low.
REQ-023 rfifo_wrreq SHALL equal (buf_count != 0) & ~rfifo_wrfull; rfifo_data SHALL be the buffer head; order preserved.
REQ-024 Simultaneous buffer write and read SHALL leave buf_count unchanged; pointers wrap modulo BUF_DEPTH.
REQ-025 Credit rule (REQ-017) SHALL guarantee no buffer overflow under any rfifo_wrfull pattern; overflow is a design error.
REQ-026 enable low SHALL stop new reads only; in-flight and buffered words drain normally.
REQ-027 mode change SHALL affect only reads issued after the change.
REQ-028 xfer_count SHALL increment on each rfifo_wrreq cycle, wrapping 2^32-1 -> 0.
REQ-029 idle SHALL be high iff inflight == 0 and buf_count == 0.

Reset
REQ-030 On reset_n low, immediately: sfifo_rdreq 0 if enable low else per REQ-017 with zero counts; rfifo_wrreq 0; rfifo_data 0; xfer_count 0; idle 1; pipeline, buffer pointers, inflight, seq all 0.
REQ-031 Reset mid-operation SHALL drop all in-flight and buffered words without emitting them.

Verification
REQ-032 LATENCY=2, mode 0, push 0x000011 then 0x000022, wrfull low -> wrreq at cycles 4 and 5 after first rdreq, data 0x000011, 0x000022; xfer_count 2; idle 1 afterwards.
REQ-033 mode 1, input 0x0000FF -> output 0xFFFF00; mode 2, inputs 0x10,0x10,0x10 -> outputs 0x10,0x11,0x12.
REQ-034 mode 3, push 5 words -> no wrreq, xfer_count 0, idle returns 1 after LATENCY+2 cycles.
REQ-035 BUF_DEPTH=8, wrfull held high, 20 words available -> exactly 8 rdreq, then rdreq 0; release wrfull -> 20 outputs in order, none lost or duplicated.
REQ-036 STF_WIDTH=32, RTF_WIDTH=16, input 0xDEADBEEF -> 0xBEEF; STF_WIDTH=8, RTF_WIDTH=16, input 0xA5 -> 0x00A5.
REQ-037 Assert reset_n low with 3 words in flight and 4 buffered -> no wrreq after release until new stimulus; xfer_count 0; seq restarts at 0.

Source files
------------

// File: rtl/loopback_pipe.sv
// loopback_pipe: pulls words from a stimulus FIFO, applies a per-word
// transform, delays them through a register pipeline and pushes them into a
// result FIFO through a small output buffer.  Reads are credit-limited so
// the output buffer can never overflow, whatever back-pressure the result
// FIFO applies.
module loopback_pipe #(
    parameter int STF_WIDTH = 24,
    parameter int RTF_WIDTH = 24,
    parameter int LATENCY   = 2,
    parameter int BUF_DEPTH = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [STF_WIDTH-1:0] sfifo_data,
    output logic                 sfifo_rdreq,
    input  logic                 sfifo_rdempty,
    output logic [RTF_WIDTH-1:0] rfifo_data,
    output logic                 rfifo_wrreq,
    input  logic                 rfifo_wrfull,
    output logic [31:0]          xfer_count,
    output logic                 idle
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    typedef enum logic [1:0] {
        MODE_PASS    = 2'd0,
        MODE_INVERT  = 2'd1,
        MODE_SEQ     = 2'd2,
        MODE_DISCARD = 2'd3
    } mode_t;

    // Read issued last cycle; its data is on sfifo_data this cycle.
    logic                 read_pending;
    mode_t                pending_mode;
    logic [RTF_WIDTH-1:0] seq;

    logic [RTF_WIDTH-1:0] resized;
    logic [RTF_WIDTH-1:0] transformed;
    logic                 discard;

    logic [RTF_WIDTH-1:0] pipe_data [LATENCY];
    logic [LATENCY-1:0]   pipe_valid;
    logic [LATENCY-1:0]   pipe_discard;

    logic [CNT_W-1:0]     inflight;
    logic [CNT_W-1:0]     buf_count;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [RTF_WIDTH-1:0] mem [BUF_DEPTH];

    logic                 retire;
    logic                 buf_wr;
    logic                 buf_rd;
    logic [CNT_W:0]       occupancy;

    // Every read holds a credit until it either lands in the buffer or is
    // retired as a discard, so buffer space is reserved before the read.
    assign occupancy   = {1'b0, inflight} + {1'b0, buf_count};
    assign sfifo_rdreq = enable & ~sfifo_rdempty & (occupancy < (CNT_W+1)'(BUF_DEPTH));

    generate
        if (STF_WIDTH >= RTF_WIDTH) begin : g_truncate
            assign resized = sfifo_data[RTF_WIDTH-1:0];
        end else begin : g_extend
            assign resized = {{(RTF_WIDTH-STF_WIDTH){1'b0}}, sfifo_data};
        end
    endgenerate

    // Apply the transform selected by the mode captured alongside the read.
    always_comb begin
        transformed = resized;
        discard     = 1'b0;
        case (pending_mode)
            MODE_INVERT:  transformed = ~resized;
            MODE_SEQ:     transformed = resized + seq;
            MODE_DISCARD: discard     = 1'b1;
            default:      transformed = resized;
        endcase
    end

    // Capture stage (first pipeline register) plus the remaining delay stages.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            read_pending <= 1'b0;
            pending_mode <= MODE_PASS;
            seq          <= '0;
            pipe_valid   <= '0;
            pipe_discard <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            read_pending    <= sfifo_rdreq;
            pending_mode    <= mode_t'(mode);
            pipe_valid[0]   <= read_pending;
            pipe_discard[0] <= read_pending & discard;
            pipe_data[0]    <= transformed;
            if (read_pending && pending_mode == MODE_SEQ) begin
                seq <= seq + 1'b1;
            end
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i]   <= pipe_valid[i-1];
                pipe_discard[i] <= pipe_discard[i-1];
                pipe_data[i]    <= pipe_data[i-1];
            end
        end
    end

    assign retire = pipe_valid[LATENCY-1];
    assign buf_wr = pipe_valid[LATENCY-1] & ~pipe_discard[LATENCY-1];
    assign buf_rd = rfifo_wrreq;

    // Track reads that hold a credit but have not yet reached the buffer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= '0;
        end else begin
            case ({sfifo_rdreq, retire})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    // Buffer storage; contents are only visible while buf_count is nonzero.
    always_ff @(posedge clock) begin
        if (buf_wr) begin
            mem[wr_ptr] <= pipe_data[LATENCY-1];
        end
    end

    // Buffer pointers and fill level; pointers wrap at the power-of-2 depth.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            buf_count <= '0;
        end else begin
            if (buf_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (buf_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({buf_wr, buf_rd})
                2'b10:   buf_count <= buf_count + 1'b1;
                2'b01:   buf_count <= buf_count - 1'b1;
                default: buf_count <= buf_count;
            endcase
        end
    end

    assign rfifo_wrreq = (buf_count != '0) & ~rfifo_wrfull;
    assign rfifo_data  = (buf_count != '0) ? mem[rd_ptr] : '0;
    assign idle        = (inflight == '0) && (buf_count == '0);

    // Count every word handed to the result FIFO; wraps naturally at 2^32.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            xfer_count <= '0;
        end else if (rfifo_wrreq) begin
            xfer_count <= xfer_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_loopback_pipe.sv
// Directed bench for loopback_pipe: a queue-backed stimulus FIFO feeds the
// default-width instance; two narrow instances cover the resize cases.
module tb_loopback_pipe;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [1:0]  mode;
    logic [23:0] sfifo_data;
    logic        sfifo_rdreq;
    logic        sfifo_rdempty;
    logic [23:0] rfifo_data;
    logic        rfifo_wrreq;
    logic        rfifo_wrfull;
    logic [31:0] xfer_count;
    logic        idle;

    logic        w_empty;
    logic        w_enable;
    logic [1:0]  w_mode;
    logic        w_full;
    logic [31:0] a_sdata;
    logic        a_rdreq;
    logic [15:0] a_data;
    logic        a_wrreq;
    logic [31:0] a_xfer;
    logic        a_idle;
    logic [7:0]  b_sdata;
    logic        b_rdreq;
    logic [15:0] b_data;
    logic        b_wrreq;
    logic [31:0] b_xfer;
    logic        b_idle;

    int          test_count = 0;
    int          fail_count = 0;
    int          cyc = 0;
    int          rd_total;
    int          first_rd;
    int          last_rd;
    int          last_busy;
    int          a_seen = 0;
    int          b_seen = 0;
    logic [15:0] a_last = '0;
    logic [15:0] b_last = '0;
    logic [23:0] stim_q [$];
    logic [23:0] got_q [$];
    int          wr_cyc_q [$];

    always #5 clock = ~clock;

    loopback_pipe dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .mode(mode),
        .sfifo_data(sfifo_data), .sfifo_rdreq(sfifo_rdreq), .sfifo_rdempty(sfifo_rdempty),
        .rfifo_data(rfifo_data), .rfifo_wrreq(rfifo_wrreq), .rfifo_wrfull(rfifo_wrfull),
        .xfer_count(xfer_count), .idle(idle)
    );

    loopback_pipe #(.STF_WIDTH(32), .RTF_WIDTH(16)) dut_narrow_out (
        .clock(clock), .reset_n(reset_n), .enable(w_enable), .mode(w_mode),
        .sfifo_data(a_sdata), .sfifo_rdreq(a_rdreq), .sfifo_rdempty(w_empty),
        .rfifo_data(a_data), .rfifo_wrreq(a_wrreq), .rfifo_wrfull(w_full),
        .xfer_count(a_xfer), .idle(a_idle)
    );

    loopback_pipe #(.STF_WIDTH(8), .RTF_WIDTH(16)) dut_wide_out (
        .clock(clock), .reset_n(reset_n), .enable(w_enable), .mode(w_mode),
        .sfifo_data(b_sdata), .sfifo_rdreq(b_rdreq), .sfifo_rdempty(w_empty),
        .rfifo_data(b_data), .rfifo_wrreq(b_wrreq), .rfifo_wrfull(w_full),
        .xfer_count(b_xfer), .idle(b_idle)
    );

    // One comparison: counts it, and on mismatch counts and reports the failure.
    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Queue a word into the stimulus FIFO model.
    task automatic apply_stimulus(input logic [23:0] word);
        stim_q.push_back(word);
        sfifo_rdempty = 1'b0;
    endtask

    task automatic clear_log();
        got_q.delete();
        wr_cyc_q.delete();
        rd_total  = 0;
        first_rd  = -1;
        last_rd   = -1;
        last_busy = -1;
    endtask

    // Advance one cycle: observe at the falling edge, then after the rising
    // edge present the word for any read granted this cycle.
    task automatic tick();
        logic rd;
        @(negedge clock);
        rd = sfifo_rdreq;
        if (rd) begin
            rd_total++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
        end
        if (rfifo_wrreq) begin
            got_q.push_back(rfifo_data);
            wr_cyc_q.push_back(cyc);
        end
        if (!idle) last_busy = cyc;
        if (a_wrreq) begin a_last = a_data; a_seen++; end
        if (b_wrreq) begin b_last = b_data; b_seen++; end
        @(posedge clock);
        #1;
        cyc++;
        if (rd && stim_q.size() > 0) sfifo_data = stim_q.pop_front();
        sfifo_rdempty = (stim_q.size() == 0);
    endtask

    function automatic logic [23:0] got_at(input int idx);
        return (idx < got_q.size()) ? got_q[idx] : 24'hxxxxxx;
    endfunction

    initial begin
        logic [31:0] lat;
        reset_n       = 1'b0;
        enable        = 1'b0;
        mode          = 2'd0;
        sfifo_data    = '0;
        sfifo_rdempty = 1'b1;
        rfifo_wrfull  = 1'b0;
        w_empty       = 1'b1;
        w_enable      = 1'b1;
        w_mode        = 2'd0;
        w_full        = 1'b0;
        a_sdata       = '0;
        b_sdata       = '0;
        clear_log();

        // Reset values, including the credit-driven read strobe while in reset
        #2;
        check_output("reset_rdreq", {31'd0, sfifo_rdreq}, 32'd0);
        check_output("reset_wrreq", {31'd0, rfifo_wrreq}, 32'd0);
        check_output("reset_data", {8'd0, rfifo_data}, 32'd0);
        check_output("reset_xfer", xfer_count, 32'd0);
        check_output("reset_idle", {31'd0, idle}, 32'd1);
        enable = 1'b1;
        sfifo_rdempty = 1'b0;
        #1;
        check_output("reset_rdreq_enabled", {31'd0, sfifo_rdreq}, 32'd1);
        enable = 1'b0;
        sfifo_rdempty = 1'b1;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // Width conversion on the narrow instances
        w_empty = 1'b0;
        tick();
        w_empty = 1'b1;
        a_sdata = 32'hDEADBEEF;
        b_sdata = 8'hA5;
        repeat (8) tick();
        check_output("trunc_count", a_seen, 32'd1);
        check_output("trunc_data", {16'd0, a_last}, 32'h0000BEEF);
        check_output("zext_count", b_seen, 32'd1);
        check_output("zext_data", {16'd0, b_last}, 32'h000000A5);

        // Pass-through with latency measurement
        clear_log();
        mode = 2'd0;
        enable = 1'b1;
        apply_stimulus(24'h000011);
        apply_stimulus(24'h000022);
        repeat (10) tick();
        check_output("pass_count", got_q.size(), 32'd2);
        check_output("pass_word0", {8'd0, got_at(0)}, 32'h000011);
        check_output("pass_word1", {8'd0, got_at(1)}, 32'h000022);
        lat = (wr_cyc_q.size() > 0) ? 32'(wr_cyc_q[0] - first_rd) : 32'hFFFFFFFF;
        check_output("pass_latency0", lat, 32'd4);
        lat = (wr_cyc_q.size() > 1) ? 32'(wr_cyc_q[1] - first_rd) : 32'hFFFFFFFF;
        check_output("pass_latency1", lat, 32'd5);
        check_output("pass_xfer", xfer_count, 32'd2);
        check_output("pass_idle", {31'd0, idle}, 32'd1);

        // Invert, then sequence-add with a mode change between reads
        clear_log();
        mode = 2'd1;
        apply_stimulus(24'h0000FF);
        tick();
        mode = 2'd2;
        repeat (3) apply_stimulus(24'h000010);
        repeat (12) tick();
        check_output("xform_count", got_q.size(), 32'd4);
        check_output("invert_word", {8'd0, got_at(0)}, 32'hFFFF00);
        check_output("seq_word0", {8'd0, got_at(1)}, 32'h000010);
        check_output("seq_word1", {8'd0, got_at(2)}, 32'h000011);
        check_output("seq_word2", {8'd0, got_at(3)}, 32'h000012);
        check_output("xform_xfer", xfer_count, 32'd6);

        // Discard mode after a fresh reset
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        clear_log();
        mode = 2'd3;
        repeat (5) apply_stimulus(24'h0000AA);
        repeat (12) tick();
        check_output("discard_reads", rd_total, 32'd5);
        check_output("discard_writes", got_q.size(), 32'd0);
        check_output("discard_xfer", xfer_count, 32'd0);
        check_output("discard_idle_delay", 32'(last_busy - last_rd), 32'd3);
        check_output("discard_idle", {31'd0, idle}, 32'd1);

        // Back-pressure: credits stop reads at buffer depth, then drain in order
        clear_log();
        mode = 2'd0;
        rfifo_wrfull = 1'b1;
        for (int i = 0; i < 20; i++) apply_stimulus(24'h000100 + 24'(i));
        repeat (20) tick();
        check_output("full_reads", rd_total, 32'd8);
        check_output("full_writes", got_q.size(), 32'd0);
        check_output("full_rdreq_now", {31'd0, sfifo_rdreq}, 32'd0);
        rfifo_wrfull = 1'b0;
        repeat (40) tick();
        check_output("drain_reads", rd_total, 32'd20);
        check_output("drain_count", got_q.size(), 32'd20);
        for (int i = 0; i < 20; i++) begin
            check_output($sformatf("drain_word%0d", i), {8'd0, got_at(i)}, 32'h100 + 32'(i));
        end
        check_output("drain_xfer", xfer_count, 32'd20);
        check_output("drain_idle", {31'd0, idle}, 32'd1);

        // Reset with 3 words in flight and 4 buffered
        clear_log();
        rfifo_wrfull = 1'b1;
        for (int i = 0; i < 7; i++) apply_stimulus(24'h000200 + 24'(i));
        repeat (8) tick();
        check_output("midrst_reads", rd_total, 32'd7);
        check_output("midrst_busy", {31'd0, idle}, 32'd0);
        enable = 1'b0;
        reset_n = 1'b0;
        rfifo_wrfull = 1'b0;
        #1;
        check_output("midrst_wrreq", {31'd0, rfifo_wrreq}, 32'd0);
        check_output("midrst_data", {8'd0, rfifo_data}, 32'd0);
        check_output("midrst_xfer", xfer_count, 32'd0);
        check_output("midrst_idle", {31'd0, idle}, 32'd1);
        repeat (2) tick();
        reset_n = 1'b1;
        enable = 1'b1;
        repeat (8) tick();
        check_output("midrst_no_output", got_q.size(), 32'd0);
        mode = 2'd2;
        apply_stimulus(24'h000010);
        repeat (8) tick();
        check_output("midrst_new_count", got_q.size(), 32'd1);
        check_output("midrst_seq_restart", {8'd0, got_at(0)}, 32'h000010);
        check_output("midrst_new_xfer", xfer_count, 32'd1);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
